// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants and types for the fetch queue.
// Single home for the boot address and bubble encodings.
package fetch_queue_pkg;
    localparam logic [31:0] BOOT_ADDRESS = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_PC    = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
    typedef enum logic {S_IDLE, S_REQ} req_state_e;
endpackage

// File: rtl/fq_fifo.sv
// fq_fifo: synchronous FIFO with flush; entries are {pc, instr}.
// Head data is visible combinationally; a push into a full FIFO is accepted only alongside a pop.
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;
    assign empty_o = count_q == '0;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (count_q < CW'(DEPTH) || do_pop);
    assign data_o  = mem_q[head_q];
    assign count_o = count_q;
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush_i)
            mem_q[tail_q] <= data_i;
    end
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + PW'(1);
            if (do_pop)  head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a single outstanding memory request,
// an instruction queue, and redirect/flush handling that discards in-flight data.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter int               DEPTH     = 4,
    parameter logic [XLEN-1:0]  BOOT_ADDR = XLEN'(BOOT_ADDRESS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       b_taken,
    input  logic [XLEN-1:0]            b_pc,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_instr,
    output logic                       if_id_valid,
    output logic [XLEN-1:0]            if_id_pc,
    output logic [31:0]                if_id_instr,
    output logic [$clog2(DEPTH+1)-1:0] fq_count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int W  = XLEN + 32;
    req_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d, fetch_pc;
    logic [XLEN-1:0] idpc_q, idpc_d;
    logic [31:0]     idinstr_q, idinstr_d;
    logic            idv_q, idv_d, discard_q, discard_d;
    logic            pending, push, pop, issue, hold, empty;
    logic [CW-1:0]   count, count_nxt;
    logic [W-1:0]    head;
    fq_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (b_taken),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({addr_q, imem_instr}),
        .data_o  (head),
        .count_o (count),
        .empty_o (empty)
    );
    always_comb begin
        pending   = state_q == S_REQ && !imem_ack;
        push      = state_q == S_REQ && imem_ack && !discard_q && !b_taken;
        pop       = !b_taken && !stall && !empty;
        count_nxt = b_taken ? '0 : count + CW'(push) - CW'(pop);
        // A new request may follow an ack on the same edge if the queue will still have room.
        issue     = !pending && count_nxt < CW'(DEPTH);
        fetch_pc  = b_taken ? b_pc : pc_q;
        state_d   = (pending || issue) ? S_REQ : S_IDLE;
        addr_d    = issue ? fetch_pc : addr_q;
        pc_d      = issue ? fetch_pc + XLEN'(4) : fetch_pc;
        discard_d = pending && (discard_q || b_taken);
        hold      = stall && !b_taken;
        idv_d     = hold ? idv_q : pop;
        idpc_d    = hold ? idpc_q : pop ? head[W-1:32] : XLEN'(BUBBLE_PC);
        idinstr_d = hold ? idinstr_q : pop ? head[31:0] : BUBBLE_INSTR;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= BOOT_ADDR;
            addr_q    <= '0;
            discard_q <= 1'b0;
            idv_q     <= 1'b0;
            idpc_q    <= '0;
            idinstr_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
            idv_q     <= idv_d;
            idpc_q    <= idpc_d;
            idinstr_q <= idinstr_d;
        end
    end
    assign imem_req    = state_q == S_REQ;
    assign imem_addr   = addr_q;
    assign if_id_valid = idv_q;
    assign if_id_pc    = idpc_q;
    assign if_id_instr = idinstr_q;
    assign fq_count    = count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch ordering, queue-full back-pressure,
// redirect while in flight, redirect coinciding with ack/stall, and PC wrap.
module tb_fetch_queue;
    localparam logic [31:0] K = 32'hA5A5_0000;
    logic        clk = 1'b0, rst, stall, b_taken, ack_en;
    logic        imem_req, imem_ack, if_id_valid;
    logic [31:0] b_pc, imem_addr, imem_instr, if_id_pc, if_id_instr;
    logic [2:0]  fq_count;
    int          checks = 0, failures = 0, acks;
    logic [31:0] e;
    always #5 clk = ~clk;
    assign imem_ack   = ack_en && imem_req;
    assign imem_instr = imem_addr ^ K;
    fetch_queue #(.XLEN(32), .DEPTH(4), .BOOT_ADDR(32'h100)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .b_taken     (b_taken),
        .b_pc        (b_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_instr  (imem_instr),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .fq_count    (fq_count)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic do_reset;
        rst = 1'b1; stall = 1'b0; b_taken = 1'b1; b_pc = 32'h300; ack_en = 1'b1;
        tick(2);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_cnt", fq_count, 0);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_pc", if_id_pc, 0);
        chk("rst_instr", if_id_instr, 0);
        rst = 1'b0; b_taken = 1'b0; ack_en = 1'b0;
    endtask
    initial begin
        do_reset();
        ack_en = 1'b1;
        tick();
        chk("boot_addr0", imem_addr, 32'h100);
        chk("boot_req", imem_req, 1);
        tick();
        chk("boot_addr1", imem_addr, 32'h104);
        chk("boot_nobypass", if_id_valid, 0);
        chk("boot_cnt", fq_count, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            e = 32'h100 + 32'(4 * i);
            chk("boot_pc", if_id_pc, e);
            chk("boot_instr", if_id_instr, e ^ K);
            chk("boot_valid", if_id_valid, 1);
            chk("boot_addr", imem_addr, e + 32'h8);
        end
        do_reset();
        stall = 1'b1; ack_en = 1'b1; acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_ack) acks++;
            tick();
        end
        chk("full_acks", acks, 4);
        chk("full_cnt", fq_count, 4);
        chk("full_req", imem_req, 0);
        chk("full_hold", if_id_valid, 0);
        stall = 1'b0; ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_pc", if_id_pc, 32'h100 + 32'(4 * i));
            chk("drain_valid", if_id_valid, 1);
            chk("drain_cnt", fq_count, 3 - i);
        end
        tick();
        chk("drain_bubble", if_id_valid, 0);
        do_reset();
        tick();
        ack_en = 1'b1;
        tick(2);
        ack_en = 1'b0;
        chk("fl_pending", imem_addr, 32'h108);
        b_taken = 1'b1; b_pc = 32'h200;
        tick();
        b_taken = 1'b0;
        chk("fl_keepaddr", imem_addr, 32'h108);
        chk("fl_keepreq", imem_req, 1);
        chk("fl_cnt", fq_count, 0);
        chk("fl_bubble", if_id_valid, 0);
        tick(2);
        ack_en = 1'b1;
        tick();
        chk("fl_newaddr", imem_addr, 32'h200);
        chk("fl_dropcnt", fq_count, 0);
        tick();
        chk("fl_no108", if_id_valid, 0);
        tick();
        chk("fl_pc200", if_id_pc, 32'h200);
        chk("fl_valid", if_id_valid, 1);
        do_reset();
        ack_en = 1'b1;
        tick(3);
        chk("co_pre", if_id_pc, 32'h100);
        stall = 1'b1; b_taken = 1'b1; b_pc = 32'h200;
        tick();
        stall = 1'b0; b_taken = 1'b0;
        chk("co_cnt", fq_count, 0);
        chk("co_valid", if_id_valid, 0);
        chk("co_pc", if_id_pc, 0);
        chk("co_instr", if_id_instr, 0);
        chk("co_addr", imem_addr, 32'h200);
        tick(2);
        chk("co_pc200", if_id_pc, 32'h200);
        do_reset();
        b_taken = 1'b1; b_pc = 32'hFFFF_FFFC; ack_en = 1'b1;
        tick();
        b_taken = 1'b0;
        chk("wr_addr_hi", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wr_addr_0", imem_addr, 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            e = 32'hFFFF_FFFC + 32'(4 * i);
            chk("wr_pc", if_id_pc, e);
            chk("wr_instr", if_id_instr, e ^ K);
            chk("wr_cnt", fq_count, 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
